// File: rtl/status_led_ctrl.sv
// Multi-channel status-LED driver.
// A shared prescaler produces a registered one-clock tick. Each channel runs
// OFF, ON, BLINK or CODE (N flashes then a pause) and can change mode at run time.
module status_led_ctrl #(
  parameter int CH          = 4,
  parameter int TICK_DIV    = 2500000,
  parameter int BLINK_TICKS = 5,
  parameter int PAUSE_TICKS = 10,
  parameter int CODE_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2*CH-1:0]      mode_i,
  input  logic [CODE_W*CH-1:0] code_i,
  input  logic                 sync_i,
  output logic                 tick_o,
  output logic [CH-1:0]        led_o
);

  localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (BLINK_TICKS > PAUSE_TICKS) ? BLINK_TICKS : PAUSE_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  BLINK_LAST  = PH_W'(BLINK_TICKS - 1);
  localparam logic [PH_W-1:0]  PAUSE_LAST  = PH_W'(PAUSE_TICKS - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Prescaler next state; sync restarts the count and suppresses a pending tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (sync_i) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [1:0]        mode_ch;
      logic [CODE_W-1:0] code_ch;
      logic              restart;
      logic [1:0]        mode_q, mode_d;
      logic [1:0]        state_q, state_d;
      logic [PH_W-1:0]   phase_q, phase_d;
      logic [CODE_W-1:0] rem_q, rem_d;
      logic              led_q, led_d;

      assign mode_ch = mode_i[2*gi +: 2];
      assign code_ch = code_i[CODE_W*gi +: CODE_W];
      assign restart = sync_i || (mode_ch != mode_q);

      // Channel next state: a restart takes priority over any tick in the same cycle.
      always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        led_d   = led_q;
        if (restart) begin
          mode_d  = mode_ch;
          state_d = ST_LOAD;
          phase_d = '0;
          led_d   = (mode_ch == MODE_ON) || (mode_ch == MODE_BLINK);
        end else begin
          case (mode_q)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            MODE_BLINK: begin
              if (tick_q) begin
                if (phase_q == BLINK_LAST) begin
                  led_d   = ~led_q;
                  phase_d = '0;
                end else begin
                  phase_d = phase_q + PH_W'(1);
                end
              end
            end
            default: begin
              case (state_q)
                ST_LOAD: begin
                  // Flash count is captured only here, so mid-sequence edits wait.
                  rem_d = code_ch;
                  if (code_ch == '0) begin
                    state_d = ST_PAUSE;
                    led_d   = 1'b0;
                  end else begin
                    state_d = ST_ON;
                    led_d   = 1'b1;
                  end
                end
                ST_ON: begin
                  if (tick_q) begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                  end
                end
                ST_OFF: begin
                  if (tick_q) begin
                    rem_d = rem_q - CODE_W'(1);
                    if (rem_q == CODE_W'(1)) begin
                      state_d = ST_PAUSE;
                      phase_d = '0;
                    end else begin
                      state_d = ST_ON;
                      led_d   = 1'b1;
                    end
                  end
                end
                default: begin
                  led_d = 1'b0;
                  if (tick_q) begin
                    if (phase_q == PAUSE_LAST) begin
                      state_d = ST_LOAD;
                      phase_d = '0;
                    end else begin
                      phase_d = phase_q + PH_W'(1);
                    end
                  end
                end
              endcase
            end
          endcase
        end
      end

      // Channel registers; reset leaves mode_q at OFF so a live mode restarts on the first clock.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mode_q  <= MODE_OFF;
          state_q <= ST_LOAD;
          phase_q <= '0;
          rem_q   <= '0;
          led_q   <= 1'b0;
        end else begin
          mode_q  <= mode_d;
          state_q <= state_d;
          phase_q <= phase_d;
          rem_q   <= rem_d;
          led_q   <= led_d;
        end
      end

      assign led_o[gi] = led_q;
    end
  endgenerate

endmodule
